// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller reads instruction fields and the ALU flag and drives every strobe and select.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       pcwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [2:0] immsrc;
    logic       retire;
    logic       illegal;

    modport slave (
        input  op, funct3, zero,
        output pcwrite, adrsrc, irwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, retire, illegal
    );

    modport master (
        output op, funct3, zero,
        input  pcwrite, adrsrc, irwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, aluop, immsrc, retire, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: state register plus state-decoded datapath controls.
// Outputs follow the state directly so the first FETCH is visible as soon as reset releases.
module multicycle_controller #(
    parameter int unsigned ENABLE_BNE = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, JAL, EXECJALR, JALRPC, BRANCH, LUI
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t state_reg;
    logic   op_known;
    logic   beq_sel;
    logic   bne_sel;
    logic   branch_ok;
    logic   branch_taken;

    always_comb begin
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_JALR, OP_BRANCH, OP_LUI: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    assign beq_sel      = (bus.funct3 == 3'b000);
    assign bne_sel      = (ENABLE_BNE != 0) && (bus.funct3 == 3'b001);
    assign branch_ok    = beq_sel | bne_sel;
    assign branch_taken = (beq_sel & bus.zero) | (bne_sel & ~bus.zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            case (state_reg)
                FETCH:  state_reg <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_reg <= MEMADR;
                        OP_R:         state_reg <= EXECR;
                        OP_I:         state_reg <= EXECI;
                        OP_JAL:       state_reg <= JAL;
                        OP_JALR:      state_reg <= EXECJALR;
                        OP_BRANCH:    state_reg <= BRANCH;
                        OP_LUI:       state_reg <= LUI;
                        default:      state_reg <= FETCH;
                    endcase
                end
                MEMADR:   state_reg <= (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  state_reg <= MEMWB;
                EXECJALR: state_reg <= JALRPC;
                EXECR, EXECI, JAL, JALRPC, LUI: state_reg <= ALUWB;
                default:  state_reg <= FETCH;
            endcase
        end
    end

    logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, retire, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop;
    logic [2:0] immsrc;

    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        immsrc    = 3'b000;
        case (state_reg)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
                illegal = ~op_known;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (bus.op == OP_SW) ? 3'b001 : 3'b000;
            end
            MEMREAD: adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            JAL, JALRPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
            end
            EXECJALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
                immsrc  = 3'b100;
            end
            BRANCH: begin
                // pcwrite follows the live zero flag within this cycle
                alusrca = 2'b10;
                aluop   = 2'b01;
                pcwrite = branch_ok & branch_taken;
                retire  = branch_ok;
                illegal = ~branch_ok;
            end
            default: ;
        endcase
    end

    // Every strobe is forced low while reset is held, including the FETCH write enables.
    assign bus.pcwrite   = rst_n & pcwrite;
    assign bus.adrsrc    = rst_n & adrsrc;
    assign bus.irwrite   = rst_n & irwrite;
    assign bus.memwrite  = rst_n & memwrite;
    assign bus.regwrite  = rst_n & regwrite;
    assign bus.retire    = rst_n & retire;
    assign bus.illegal   = rst_n & illegal;
    assign bus.resultsrc = rst_n ? resultsrc : 2'b00;
    assign bus.alusrca   = rst_n ? alusrca   : 2'b00;
    assign bus.alusrcb   = rst_n ? alusrcb   : 2'b00;
    assign bus.aluop     = rst_n ? aluop     : 2'b00;
    assign bus.immsrc    = rst_n ? immsrc    : 3'b000;
endmodule
